wsg_pwm_dac: RTL and testbench
==============================

// Module: wsg_pwm_dac
// PURPOSE
//  Audio back end fed by the WSG mixer's pwm_dat. Buffers one 8-bit sample per PWM period
//  via a valid/ready handshake and drives a single-bit PWM pin (RC-filtered off-chip).
//  At clk = 24.576 MHz and DW = 8, the PWM period is 256 clk, i.e. 96 kHz, one period per WSG sample.
//  Soft-mute ramps duty to midscale to avoid pops.
// PARAMETERS
//  DW   8    sample / counter width; PWM period = 2**DW clk
//  MID  128  midscale duty: reset level and mute target (< 2**DW)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-low reset (0 = in reset)
//  sample_dat    in   DW  unsigned sample from mixer (pwm_dat)
//  sample_valid  in   1   sample_dat valid this cycle
//  sample_ready  out  1   shadow buffer empty; transfer on valid && ready
//  mute          in   1   level: ramp duty to MID, discard incoming samples
//  pwm_out       out  1   PWM output pin
//  muted         out  1   mute && duty == MID
//  underrun      out  1   sticky: period boundary with empty shadow (after arming)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - State: cnt=0, duty=MID, shadow=MID, full=0, armed=0.
//   - Outputs: pwm_out=0, underrun=0.
//   - sample_ready = reset && !full, so it is 0 while reset is low.
//   - Reset mid-period aborts the period; a sample held in shadow is lost.
//  Counter: cnt (DW bits) increments every clk, wraps 2**DW-1 -> 0. Boundary cycle = cnt==2**DW-1.
//  Output: pwm_out <= (cnt < duty), registered, so it lags cnt by 1 clk.
//   - Each 2**DW window therefore holds exactly duty high cycles.
//   - duty=0 gives constant 0; duty=2**DW-1 gives 2**DW-1 high cycles and 1 low.
//  Handshake: on valid && ready, shadow <= sample_dat, full <= 1, armed <= 1.
//   - ready is low while full, so no accept can coincide with a full shadow.
//   - Valid held against !ready is legal backpressure; no flag is raised.
//   - sample_dat is only sampled on accept.
//  Boundary update (mute==0), at the boundary clk edge:
//   - full=1: duty <= shadow, full <= 0.
//   - full=0: duty held; underrun <= 1 if armed.
//   - Accept on the boundary cycle itself (shadow was empty): the sample goes to shadow and is
//     used at the NEXT boundary. The current boundary counts as empty, so underrun is set if armed.
//  Boundary update (mute==1):
//   - duty moves one step toward MID (+1 or -1; held if equal).
//   - If full: shadow is discarded, full <= 0. No underrun is flagged while muted.
//  Unmute: the next boundary with full=1 loads shadow directly; no ramp up.
//  Latency: accept at cycle t -> duty loaded at the first boundary after t.
//   - New duty is visible on pwm_out from cnt==0 + 1 clk.
//  muted is combinational from mute and duty. underrun clears only by reset.
// TESTING
//  1 reset low 4 clk -> pwm_out=0, sample_ready=0, underrun=0. Release -> 128 high per 256 clk; underrun stays 0 (not armed).
//  2 send 0x40 mid-period -> ready drops; first full period after the boundary shows 64 high clk; ready returns at the boundary.
//  3 send 0x00, then 0xFF at the next ready -> one period of all-low, then 255 high + 1 low.
//  4 send one sample, then nothing -> second boundary sets underrun=1 (sticky); a later sample does not clear it.
//  5 duty=0xC8, assert mute, keep feeding samples -> duty falls 1 per period; muted=1 after 72 boundaries; no underrun, no stall.
//  6 reset pulse at cnt=100 with full=1 -> cnt=0, duty=MID, shadow discarded, ready=1 one clk after release.

Source files
------------

// File: rtl/wsg_pwm_dac.sv
// wsg_pwm_dac -- PWM audio back end for the WSG mixer.
//
// Holds one pending sample in a shadow buffer. The buffer is filled through a
// valid/ready handshake and copied into the active duty at the end of each
// 2**DW-clock PWM period. A single-bit PWM pin carries the audio and is
// RC-filtered off-chip. While mute is high, duty walks one step per period
// toward midscale and incoming samples are dropped, so muting does not pop.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-low reset (0 = in reset)
//   sample_dat    in   DW-bit unsigned sample (mixer pwm_dat)
//   sample_valid  in   sample_dat is valid this cycle
//   sample_ready  out  shadow buffer is empty; a transfer happens on valid && ready
//   mute          in   level: ramp duty toward MID and discard samples
//   pwm_out       out  registered PWM pin
//   muted         out  mute is high and duty has reached MID
//   underrun      out  sticky: a period ended with an empty shadow after the first sample
module wsg_pwm_dac #(
  parameter int DW  = 8,
  parameter int MID = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] sample_dat,
  input  logic          sample_valid,
  output logic          sample_ready,
  input  logic          mute,
  output logic          pwm_out,
  output logic          muted,
  output logic          underrun
);

  localparam logic [DW-1:0] MID_V   = DW'(MID);
  localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};

  logic [DW-1:0] cnt_r;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] shadow_r;
  logic          full_r;
  logic          armed_r;
  logic          pwm_r;
  logic          underrun_r;

  logic [DW-1:0] duty_nxt_s;
  logic [DW-1:0] shadow_nxt_s;
  logic          full_nxt_s;
  logic          armed_nxt_s;
  logic          underrun_nxt_s;
  logic          boundary_s;
  logic          accept_s;

  // One mute-ramp step: move duty by one toward MID, or hold it once it is there.
  function automatic logic [DW-1:0] step_toward_mid(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    if (d < MID_V) begin
      r = d + DW'(1);
    end else if (d > MID_V) begin
      r = d - DW'(1);
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Handshake and output flags. sample_ready is gated by reset so it stays low during reset.
  always_comb begin
    sample_ready = reset && !full_r;
    muted        = mute && (duty_r == MID_V);
    pwm_out      = pwm_r;
    underrun     = underrun_r;
  end

  // Next state for the shadow buffer, duty and flags.
  always_comb begin
    boundary_s     = (cnt_r == CNT_MAX);
    accept_s       = sample_valid && sample_ready;
    duty_nxt_s     = duty_r;
    shadow_nxt_s   = shadow_r;
    full_nxt_s     = full_r;
    armed_nxt_s    = armed_r;
    underrun_nxt_s = underrun_r;

    if (boundary_s) begin
      if (mute) begin
        // A muted boundary ramps duty and drops any pending sample.
        // Underrun is not flagged while muted.
        duty_nxt_s = step_toward_mid(duty_r);
        full_nxt_s = 1'b0;
      end else if (full_r) begin
        duty_nxt_s = shadow_r;
        full_nxt_s = 1'b0;
      end else if (armed_r) begin
        underrun_nxt_s = 1'b1;
      end else begin
        duty_nxt_s = duty_r;
      end
    end else begin
      duty_nxt_s = duty_r;
    end

    // An accept can only happen while the shadow is empty, so it never
    // collides with a boundary load. An accept on the boundary cycle is
    // held for the next boundary.
    if (accept_s) begin
      shadow_nxt_s = sample_dat;
      full_nxt_s   = 1'b1;
      armed_nxt_s  = 1'b1;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // State registers, plus the PWM comparator. pwm_out is registered, so it lags cnt by one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r      <= '0;
      duty_r     <= MID_V;
      shadow_r   <= MID_V;
      full_r     <= 1'b0;
      armed_r    <= 1'b0;
      pwm_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_r + DW'(1);
      duty_r     <= duty_nxt_s;
      shadow_r   <= shadow_nxt_s;
      full_r     <= full_nxt_s;
      armed_r    <= armed_nxt_s;
      pwm_r      <= (cnt_r < duty_r);
      underrun_r <= underrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_wsg_pwm_dac.sv
// Testbench for wsg_pwm_dac.
// The reference model works one period at a time. It tracks the position in
// the period, the current duty, and a queue holding at most one pending
// sample. Each clock it predicts pwm_out, sample_ready, underrun and muted.
module tb_wsg_pwm_dac;

  logic       clk;
  logic       reset;
  logic [7:0] sample_dat;
  logic       sample_valid;
  logic       sample_ready;
  logic       mute;
  logic       pwm_out;
  logic       muted;
  logic       underrun;

  wsg_pwm_dac #(.DW(8), .MID(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_dat   (sample_dat),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .pwm_out      (pwm_out),
    .muted        (muted),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_phase = 0;   // clocks since the start of the current period
  int m_duty  = 128; // high clocks per period
  int m_q[$];        // pending sample (at most one entry)
  bit m_armed = 1'b0;
  bit m_under = 1'b0;
  bit m_pwm   = 1'b0;

  int hi_acc  = 0;   // pwm_out high clocks, summed by tick
  int acc_cnt = 0;   // samples accepted
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Update the model from the inputs that were stable at
  // the edge, then compare the DUT outputs with the model.
  task automatic tick();
    bit acc;
    @(posedge clk);
    #1;
    acc = 1'b0;
    if (!reset) begin
      m_phase = 0;
      m_duty  = 128;
      m_q.delete();
      m_armed = 1'b0;
      m_under = 1'b0;
      m_pwm   = 1'b0;
    end else begin
      acc   = sample_valid && (m_q.size() == 0);
      m_pwm = (m_phase < m_duty);
      if (m_phase == 255) begin
        if (mute) begin
          if (m_duty < 128) m_duty++;
          else if (m_duty > 128) m_duty--;
          m_q.delete();
        end else if (m_q.size() > 0) begin
          m_duty = m_q.pop_front();
        end else if (m_armed) begin
          m_under = 1'b1;
        end
      end
      if (acc) begin
        m_q.push_back(int'(sample_dat));
        m_armed = 1'b1;
        acc_cnt++;
      end
      m_phase = (m_phase + 1) % 256;
    end
    last_acc = acc;
    if (pwm_out === 1'b1) hi_acc++;
    chk("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
    chk("sample_ready", {31'd0, sample_ready}, {31'd0, (reset && (m_q.size() == 0))});
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
    chk("muted", {31'd0, muted}, {31'd0, (mute && (m_duty == 128))});
  endtask

  // Advance at least one clock, until the model is at period position p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (m_phase != p && n < 600);
    chk("wait_phase_timeout", {31'd0, (m_phase != p)}, 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one sample until it is accepted, within a bounded number of clocks.
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    sample_dat   = d;
    sample_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 600);
    sample_valid = 1'b0;
    chk("send_timeout", {31'd0, last_acc}, 32'd1);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    sample_dat   = 8'h00;
    sample_valid = 1'b0;
    mute         = 1'b0;

    // 1: reset state, then midscale with no underrun.
    run(4);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b1;
    run(10);
    hi_acc = 0;
    run(256);
    chk("t1_high", hi_acc, 32'd128);
    run(300);
    chk("t1_underrun", {31'd0, underrun}, 32'd0);

    // 2: a sample sent mid-period is used from the next period on.
    wait_phase(50);
    send(8'h40);
    chk("t2_ready_low", {31'd0, sample_ready}, 32'd0);
    wait_phase(0);
    chk("t2_ready_back", {31'd0, sample_ready}, 32'd1);
    hi_acc = 0;
    run(256);
    chk("t2_high", hi_acc, 32'd64);

    // 3: a full-low period followed by 255 high clocks.
    send(8'h00);
    wait_phase(0);
    hi_acc = 0;
    send(8'hFF);
    wait_phase(0);
    chk("t3_low_period", hi_acc, 32'd0);
    hi_acc = 0;
    run(256);
    chk("t3_high", hi_acc, 32'd255);

    // 4: underrun is sticky.
    reset_pulse();
    send(8'h33);
    wait_phase(0);
    chk("t4_no_underrun_yet", {31'd0, underrun}, 32'd0);
    wait_phase(0);
    chk("t4_underrun", {31'd0, underrun}, 32'd1);
    send(8'h10);
    wait_phase(0);
    chk("t4_sticky", {31'd0, underrun}, 32'd1);

    // 5: mute ramps duty from 0xC8 down to MID; samples are still accepted.
    reset_pulse();
    send(8'hC8);
    wait_phase(0);
    mute         = 1'b1;
    sample_valid = 1'b1;
    acc_cnt      = 0;
    for (int i = 0; i < 71 * 256; i++) begin
      sample_dat = 8'($urandom);
      tick();
    end
    chk("t5_not_muted_71", {31'd0, muted}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      sample_dat = 8'($urandom);
      tick();
    end
    chk("t5_muted_72", {31'd0, muted}, 32'd1);
    chk("t5_no_underrun", {31'd0, underrun}, 32'd0);
    chk("t5_no_stall", {31'd0, (acc_cnt >= 72)}, 32'd1);
    sample_valid = 1'b0;
    mute         = 1'b0;
    send(8'h20);
    wait_phase(0);
    hi_acc = 0;
    run(256);
    chk("t5_unmute_direct", hi_acc, 32'd32);

    // 6: reset mid-period with a sample pending.
    reset_pulse();
    send(8'h77);
    wait_phase(100);
    reset = 1'b0;
    tick();
    chk("t6_ready_in_reset", {31'd0, sample_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_ready_release", {31'd0, sample_ready}, 32'd1);
    hi_acc = 0;
    run(256);
    chk("t6_mid_duty", hi_acc, 32'd128);

    // Random traffic: valid, data and occasional mute toggles.
    for (int i = 0; i < 4000; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_dat   = 8'($urandom);
      if ($urandom_range(0, 499) == 0) mute = !mute;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
